// File: rtl/wb_write_arbiter.sv
// Register-file writeback arbiter: the pipeline result (A) has priority, and long-latency
// results (B) wait in a 2-entry FIFO. A busy scoreboard tracks outstanding long-latency destinations.
module wb_write_arbiter #(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int ADDR_SIZE   = 32,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   a_valid,
  input  logic [RFIDX_WIDTH-1:0] a_rd,
  input  logic [XLEN-1:0]        a_data,
  input  logic [ADDR_SIZE-1:0]   a_pc,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [RFIDX_WIDTH-1:0] b_rd,
  input  logic [XLEN-1:0]        b_data,
  input  logic [ADDR_SIZE-1:0]   b_pc,
  input  logic                   iss_valid,
  input  logic [RFIDX_WIDTH-1:0] iss_rd,
  input  logic [RFIDX_WIDTH-1:0] chk_rs1,
  input  logic [RFIDX_WIDTH-1:0] chk_rs2,
  output logic                   busy_rs1,
  output logic                   busy_rs2,
  output logic                   we3,
  output logic [RFIDX_WIDTH-1:0] wa3,
  output logic [XLEN-1:0]        wd3,
  output logic [ADDR_SIZE-1:0]   wpc
);

  localparam int NREGS = 1 << RFIDX_WIDTH;

  logic [RFIDX_WIDTH-1:0] fifo_rd   [FIFO_DEPTH];
  logic [XLEN-1:0]        fifo_data [FIFO_DEPTH];
  logic [ADDR_SIZE-1:0]   fifo_pc   [FIFO_DEPTH];
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic [1:0]             count;

  logic [NREGS-1:0]       busy;
  logic [NREGS-1:0]       busy_next;

  logic                   sel_a;
  logic                   sel_b;
  logic                   push;
  logic [RFIDX_WIDTH-1:0] head_rd;

  // Selection looks only at entries already stored, so a fresh push waits at least one cycle.
  always_comb begin
    b_ready = (count != 2'd2);
    push    = b_valid && b_ready;
    sel_a   = a_valid && (a_rd != '0);
    sel_b   = !sel_a && (count != 2'd0);
    head_rd = fifo_rd[rd_ptr];
  end

  always_comb begin
    busy_next = busy;
    if (sel_b && (head_rd != '0))
      busy_next[head_rd] = 1'b0;
    // A reissue in the same cycle as the clear keeps the register busy.
    if (iss_valid && (iss_rd != '0))
      busy_next[iss_rd] = 1'b1;
  end

  always_comb begin
    busy_rs1 = (chk_rs1 != '0) && busy[chk_rs1];
    busy_rs2 = (chk_rs2 != '0) && busy[chk_rs2];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_rd[i]   <= '0;
        fifo_data[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else begin
      if (push) begin
        fifo_rd[wr_ptr]   <= b_rd;
        fifo_data[wr_ptr] <= b_data;
        fifo_pc[wr_ptr]   <= b_pc;
        wr_ptr            <= ~wr_ptr;
      end
      if (sel_b)
        rd_ptr <= ~rd_ptr;
      case ({push, sel_b})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      busy <= '0;
    else
      busy <= busy_next;
  end

  // A FIFO head with rd=0 is still consumed, but it produces no register write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we3 <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
      wpc <= '0;
    end else if (sel_a) begin
      we3 <= 1'b1;
      wa3 <= a_rd;
      wd3 <= a_data;
      wpc <= a_pc;
    end else if (sel_b) begin
      we3 <= (head_rd != '0);
      wa3 <= head_rd;
      wd3 <= fifo_data[rd_ptr];
      wpc <= fifo_pc[rd_ptr];
    end else begin
      we3 <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
      wpc <= '0;
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Testbench for wb_write_arbiter: directed scenarios plus random traffic against a queue-based
// reference model; expected writes go to a scoreboard queue consumed by an independent monitor.
module tb_wb_write_arbiter;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
  } bres_t;

  typedef struct {
    bit          we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] wpc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        a_valid, b_valid, iss_valid;
  logic [4:0]  a_rd, b_rd, iss_rd, chk_rs1, chk_rs2;
  logic [31:0] a_data, b_data, a_pc, b_pc;
  logic        b_ready, busy_rs1, busy_rs2, we3;
  logic [4:0]  wa3;
  logic [31:0] wd3, wpc;

  int    checks = 0;
  int    errors = 0;
  bit    in_reset = 1'b1;
  bres_t bfifo[$];
  exp_t  exp_q[$];
  bit    busy_m[32];

  wb_write_arbiter dut (
    .clk(clk), .rstn(rstn),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_pc(a_pc),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data), .b_pc(b_pc),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .busy_rs1(busy_rs1), .busy_rs2(busy_rs2),
    .we3(we3), .wa3(wa3), .wd3(wd3), .wpc(wpc)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: after every rising edge, the next expected write record is compared with the port.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!in_reset) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_output("we3", {127'd0, we3}, {127'd0, e.we});
          if (e.we)
            check_output("write_fields", {wa3, wd3, wpc}, {e.wa, e.wd, e.wpc});
        end else begin
          check_output("we3_idle", {127'd0, we3}, 128'd0);
        end
      end
    end
  end

  // One cycle of stimulus: drive inputs, check combinational outputs, then advance the model.
  task automatic apply_stimulus(
    input bit av, input logic [4:0] ar, input logic [31:0] ad, input logic [31:0] ap,
    input bit bv, input logic [4:0] br, input logic [31:0] bd, input logic [31:0] bp,
    input bit iv, input logic [4:0] ir, input logic [4:0] c1, input logic [4:0] c2);
    exp_t  e;
    bres_t h;
    bit    ready_m;
    @(negedge clk);
    a_valid = av; a_rd = ar; a_data = ad; a_pc = ap;
    b_valid = bv; b_rd = br; b_data = bd; b_pc = bp;
    iss_valid = iv; iss_rd = ir; chk_rs1 = c1; chk_rs2 = c2;
    #1;
    ready_m = (bfifo.size() < 2);
    check_output("b_ready", {127'd0, b_ready}, {127'd0, ready_m});
    check_output("busy_rs1", {127'd0, busy_rs1}, {127'd0, (c1 != 0) && busy_m[c1]});
    check_output("busy_rs2", {127'd0, busy_rs2}, {127'd0, (c2 != 0) && busy_m[c2]});
    e = '{we: 1'b0, wa: 5'd0, wd: 32'd0, wpc: 32'd0};
    if (av && ar != 0) begin
      e = '{we: 1'b1, wa: ar, wd: ad, wpc: ap};
    end else if (bfifo.size() > 0) begin
      h = bfifo.pop_front();
      if (h.rd != 0) begin
        e = '{we: 1'b1, wa: h.rd, wd: h.data, wpc: h.pc};
        busy_m[h.rd] = 1'b0;
      end
    end
    if (bv && ready_m)
      bfifo.push_back('{rd: br, data: bd, pc: bp});
    if (iv && ir != 0)
      busy_m[ir] = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic [4:0] c1);
    for (int i = 0; i < n; i++)
      apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c1, 0);
  endtask

  task automatic do_reset(input logic [4:0] c1);
    @(negedge clk);
    in_reset = 1'b1;
    rstn = 1'b0;
    a_valid = 0; b_valid = 0; iss_valid = 0; chk_rs1 = c1; chk_rs2 = 0;
    #1;
    check_output("rst_we3", {127'd0, we3}, 128'd0);
    check_output("rst_fields", {wa3, wd3, wpc}, 128'd0);
    check_output("rst_b_ready", {127'd0, b_ready}, 128'd1);
    check_output("rst_busy_rs1", {127'd0, busy_rs1}, 128'd0);
    bfifo.delete();
    exp_q.delete();
    for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    in_reset = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    a_valid = 0; a_rd = 0; a_data = 0; a_pc = 0;
    b_valid = 0; b_rd = 0; b_data = 0; b_pc = 0;
    iss_valid = 0; iss_rd = 0; chk_rs1 = 0; chk_rs2 = 0;
    for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
    do_reset(0);

    // A-only write
    apply_stimulus(1, 5, 32'h1234, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2, 0);

    // A conflicts with two B pushes; third B offer is refused while full
    apply_stimulus(1, 3, 32'hAA, 32'h200, 1, 7, 32'hBB, 32'h300, 0, 0, 0, 0);
    apply_stimulus(1, 3, 32'hAA, 32'h204, 1, 8, 32'hCC, 32'h304, 0, 0, 0, 0);
    apply_stimulus(1, 3, 32'hAA, 32'h208, 1, 9, 32'hDD, 32'h308, 0, 0, 0, 0);
    idle(4, 0);

    // A with rd=0 must not block the FIFO head
    apply_stimulus(1, 0, 32'h11, 32'h400, 1, 9, 32'h55, 32'h500, 0, 0, 0, 0);
    apply_stimulus(1, 0, 32'h22, 32'h404, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2, 0);

    // Busy scoreboard on x12, then a same-cycle reissue while clearing
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 12, 0);
    apply_stimulus(0, 0, 0, 0, 1, 12, 32'h77, 32'h600, 0, 0, 12, 12);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 0);
    apply_stimulus(0, 0, 0, 0, 1, 12, 32'h78, 32'h604, 1, 12, 12, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 12, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 12);
    idle(2, 12);

    // B result with rd=0 is consumed without a write
    apply_stimulus(0, 0, 0, 0, 1, 0, 32'hFF, 32'h700, 0, 0, 0, 0);
    idle(2, 0);
    apply_stimulus(0, 0, 0, 0, 1, 6, 32'h66, 32'h704, 0, 0, 0, 0);
    idle(2, 0);

    // Reset with two buffered entries and x4 busy
    apply_stimulus(1, 3, 32'h1, 32'h800, 1, 4, 32'h44, 32'h900, 1, 4, 4, 0);
    apply_stimulus(1, 3, 32'h2, 32'h804, 1, 5, 32'h45, 32'h904, 0, 0, 4, 0);
    apply_stimulus(1, 3, 32'h3, 32'h808, 0, 0, 0, 0, 0, 0, 4, 0);
    do_reset(4);
    idle(4, 4);

    // Random traffic over a small register range to force collisions
    for (int n = 0; n < 600; n++)
      apply_stimulus($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom, $urandom,
                     $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom, $urandom,
                     ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    idle(4, 0);

    @(negedge clk);
    check_output("scoreboard_drained", {96'd0, 32'(exp_q.size())}, 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
WB_WRITE_ARBITER -- requirements
Module: wb_write_arbiter

Interface
REQ-001 Parameters: XLEN, default 32, data width; RFIDX_WIDTH, default 5, register index width; ADDR_SIZE, default 32, pc width; FIFO_DEPTH, fixed 2, B-source buffer entries.
REQ-002 clk  in  1  sole clock; all state SHALL update on rising edge.
REQ-003 rstn  in  1  asynchronous, active-low reset.
REQ-004 a_valid  in  1  pipeline writeback result valid; no backpressure.
REQ-005 a_rd  in  RFIDX_WIDTH  destination register for A.
REQ-006 a_data  in  XLEN  A result.
REQ-007 a_pc  in  ADDR_SIZE  pc of A instruction.
REQ-008 b_valid  in  1  long-latency unit result valid.
REQ-009 b_ready  out  1  B accept; SHALL equal FIFO not full, combinational.
REQ-010 b_rd  in  RFIDX_WIDTH, b_data  in  XLEN, b_pc  in  ADDR_SIZE  B result fields.
REQ-011 iss_valid  in  1, iss_rd  in  RFIDX_WIDTH  long-latency op issued; marks iss_rd pending.
REQ-012 chk_rs1, chk_rs2  in  RFIDX_WIDTH  source registers to check.
REQ-013 busy_rs1, busy_rs2  out  1  combinational pending flag for chk_rs1/chk_rs2; SHALL be 0 for index 0.
REQ-014 we3  out  1, wa3  out  RFIDX_WIDTH, wd3  out  XLEN, wpc  out  ADDR_SIZE  registered register-file write port.

Function
REQ-015 B handshake: entry SHALL be pushed when b_valid && b_ready; b_valid SHALL be ignored when b_ready=0.
REQ-016 FIFO SHALL be 2-entry, in-order, with wrapping read/write pointers and a 2-bit count (0..2).
REQ-017 Each cycle exactly one selection: A if a_valid && a_rd!=0; else FIFO head if count>0; else none.
REQ-018 Selected result SHALL appear on we3/wa3/wd3/wpc at the next rising edge (latency 1); we3=0 when none selected.
REQ-019 FIFO head SHALL be popped only when selected; a_valid with a_rd=0 SHALL not block B.
REQ-020 FIFO head with rd=0 SHALL be popped when selected and produce we3=0.
REQ-021 Simultaneous push and pop at count=2 SHALL not occur (b_ready=0); at count=1 push+pop SHALL leave count=1 with correct order.
REQ-022 Push into an empty FIFO SHALL not be selectable in the same cycle (minimum B latency 2 edges from handshake to we3).
REQ-023 Busy vector: 32 bits (2^RFIDX_WIDTH); bit iss_rd set on iss_valid && iss_rd!=0.
REQ-024 Busy bit wa3 SHALL clear on the same edge that registers a B-sourced write of wa3 with we3=1.
REQ-025 Simultaneous set and clear of the same bit: set SHALL win.
REQ-026 A-sourced writes SHALL not alter busy bits.
REQ-027 Issue to an already-busy register is precluded upstream; no checking required.

Reset
REQ-028 rstn=0 SHALL immediately force we3=0, wa3=0, wd3=0, wpc=0, FIFO count=0, pointers=0, busy vector=0; busy_rs1/2=0, b_ready=1.
REQ-029 Reset mid-operation SHALL discard buffered B entries and all busy bits; no write SHALL be emitted for them after release.

Verification
REQ-030 A only: a_valid=1, a_rd=5, a_data=0x1234, a_pc=0x100 -> next edge we3=1, wa3=5, wd3=0x1234, wpc=0x100.
REQ-031 Conflict: A (rd=3, 0xAA) each cycle for 3 cycles while B pushes rd=7 0xBB then rd=8 0xCC -> b_ready=0 after 2 pushes; three A writes, then rd=7, then rd=8, b_ready returns 1 after first pop.
REQ-032 A rd=0 with FIFO head rd=9 0x55 -> we3=1, wa3=9, wd3=0x55 next edge.
REQ-033 Scoreboard: iss_rd=12; chk_rs1=12 -> busy_rs1=1 until B write of x12 registers, 0 from that edge; same-cycle reissue of x12 -> stays 1.
REQ-034 Reset with 2 FIFO entries and busy x4 -> all outputs 0, b_ready=1, busy_rs1(chk=4)=0, no writes after release.
REQ-035 B push rd=0 data 0xFF with A idle -> popped, we3 stays 0, count returns to 0.
